// File: rtl/fmax_window.sv
// -----------------------------------------------------------------------------
// fmax_window
//   Streaming maximum over fixed-size windows of FloPoCo floats (wE=4, wF=4).
//   Each window of WINDOW accepted elements produces one result: the largest
//   element and its position in the window. If any element is NaN, the result
//   is the canonical NaN (11'h600) and points at the first NaN.
//
//   Float layout: {exc[10:9], sign[8], exp[7:4], frac[3:0]}
//     exc 00 = zero, 01 = normal, 10 = infinity, 11 = NaN
//
// Handshake:
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. in_ready depends only on registered state and never on out_ready.
//   out_* is registered and held steady while out_valid=1 and out_ready=0.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    element to reduce
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle
//   out_data   window maximum (same float format)
//   out_idx    0-based window position of the reported element
//   out_nan    window contained at least one NaN
//   out_valid  result valid
//   out_ready  consumer accepts the result
// -----------------------------------------------------------------------------

// fcmplt: ordered less-than compare of two FloPoCo floats.
//   x_lt_y    x < y (only meaningful when unordered = 0)
//   unordered at least one operand is NaN
//   +0 and -0 compare equal; -inf < normals/zero < +inf.
module fcmplt #(
    parameter int WE = 4,
    parameter int WF = 4
) (
    input  logic [WE+WF+2:0] x,
    input  logic [WE+WF+2:0] y,
    output logic             x_lt_y,
    output logic             unordered
);
    localparam int N = WE + WF + 3;   // total width
    localparam int M = WE + WF + 2;   // magnitude key width

    // Magnitude key: zero < every normal < infinity. The exception code is
    // placed above exponent/fraction so one unsigned compare orders all
    // non-NaN magnitudes.
    function automatic logic [M-1:0] mag_of(input logic [N-1:0] v);
        logic [M-1:0] m;
        case (v[N-1:N-2])
            2'b00:   m = '0;
            2'b01:   m = {2'b01, v[WE+WF-1:0]};
            default: m = {2'b10, {(WE+WF){1'b0}}};
        endcase
        return m;
    endfunction

    logic [M-1:0] mag_x;
    logic [M-1:0] mag_y;
    logic         neg_x;
    logic         neg_y;
    logic         nan_x;
    logic         nan_y;

    always_comb begin
        mag_x = mag_of(x);
        mag_y = mag_of(y);
        nan_x = (x[N-1:N-2] == 2'b11);
        nan_y = (y[N-1:N-2] == 2'b11);
        // Zero carries no effective sign so that -0 == +0.
        neg_x = x[N-3] && (x[N-1:N-2] != 2'b00);
        neg_y = y[N-3] && (y[N-1:N-2] != 2'b00);

        unordered = nan_x || nan_y;
        x_lt_y    = 1'b0;
        if (!unordered) begin
            if (neg_x != neg_y) begin
                x_lt_y = neg_x;
            end else if (!neg_x) begin
                x_lt_y = (mag_x < mag_y);
            end else begin
                x_lt_y = (mag_x > mag_y);
            end
        end
    end
endmodule

module fmax_window #(
    parameter int ID     = 1,
    parameter int WINDOW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] out_data,
    output logic [7:0]  out_idx,
    output logic        out_nan,
    output logic        out_valid,
    input  logic        out_ready
);
    // WINDOW must fit the 8-bit position counter.
    if (WINDOW < 1 || WINDOW > 256) begin : g_bad_window
        $error("fmax_window: WINDOW out of range 1..256");
    end

    // ID is an instance tag only; it has no functional effect.
    if (ID < 0) begin : g_neg_id
    end

    localparam logic [7:0]  LAST_POS = 8'(WINDOW - 1);
    localparam logic [10:0] NAN_VAL  = 11'h600;

    typedef enum logic [1:0] {
        ACC0 = 2'd0,   // expecting element 0
        ACC  = 2'd1,   // elements 1..WINDOW-1
        HOLD = 2'd2    // result pending
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [10:0] max_q,   max_d;
    logic [7:0]  idx_q,   idx_d;
    logic        nan_q,   nan_d;

    logic accept;
    logic in_is_nan;
    logic max_lt_in;
    logic cmp_unordered;

    fcmplt #(
        .WE(4),
        .WF(4)
    ) u_cmp (
        .x         (max_q),
        .y         (in_data),
        .x_lt_y    (max_lt_in),
        .unordered (cmp_unordered)
    );

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_data  = max_q;
    assign out_idx   = idx_q;
    assign out_nan   = nan_q;

    assign accept    = in_valid && in_ready;
    assign in_is_nan = (in_data[10:9] == 2'b11);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        nan_d   = nan_q;

        case (state_q)
            ACC0: begin
                if (accept) begin
                    max_d = in_is_nan ? NAN_VAL : in_data;
                    idx_d = 8'd0;
                    nan_d = in_is_nan;
                    if (WINDOW == 1) begin
                        state_d = HOLD;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ACC;
                        cnt_d   = 8'd1;
                    end
                end
            end

            ACC: begin
                if (accept) begin
                    // Once a NaN has been seen the result is frozen.
                    if (!nan_q) begin
                        if (in_is_nan) begin
                            nan_d = 1'b1;
                            max_d = NAN_VAL;
                            idx_d = cnt_q;
                        end else if (max_lt_in && !cmp_unordered) begin
                            // Strictly greater only: ties keep the earlier one.
                            max_d = in_data;
                            idx_d = cnt_q;
                        end
                    end
                    if (cnt_q == LAST_POS) begin
                        state_d = HOLD;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    state_d = ACC0;
                end
            end

            default: begin
                state_d = ACC0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC0;
            cnt_q   <= 8'd0;
            max_q   <= 11'd0;
            idx_q   <= 8'd0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            nan_q   <= nan_d;
        end
    end
endmodule

// File: tb/tb_fmax_window.sv
module tb_fmax_window;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WINDOW=4 instance
    logic        rst_n;
    logic [10:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] out_data;
    logic [7:0]  out_idx;
    logic        out_nan;
    logic        out_valid;
    logic        out_ready;

    // WINDOW=1 instance
    logic        rst1_n;
    logic [10:0] in_data1;
    logic        in_valid1;
    logic        in_ready1;
    logic [10:0] out_data1;
    logic [7:0]  out_idx1;
    logic        out_nan1;
    logic        out_valid1;
    logic        out_ready1;

    int total = 0;
    int bad   = 0;

    // expected result = {nan, idx[7:0], data[10:0]}
    logic [19:0] exp_q[$];
    logic [19:0] exp1_q[$];
    logic [10:0] win [0:3];

    fmax_window #(.ID(1), .WINDOW(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_idx(out_idx), .out_nan(out_nan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    fmax_window #(.ID(2), .WINDOW(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .out_idx(out_idx1), .out_nan(out_nan1),
        .out_valid(out_valid1), .out_ready(out_ready1)
    );

    // ---------------- reference model ----------------
    // Ordering key for non-NaN values: -inf < negatives < 0 < positives < +inf
    function automatic int fkey(input logic [10:0] v);
        int mag;
        case (v[10:9])
            2'b00:   return 0;
            2'b01: begin
                mag = 2 + int'(v[7:4]) * 16 + int'(v[3:0]);
                return v[8] ? -mag : mag;
            end
            default: return v[8] ? -1000 : 1000;
        endcase
    endfunction

    function automatic logic [19:0] model4(input logic [10:0] w0, w1, w2, w3);
        logic [10:0] w [0:3];
        int best;
        bit nan;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        best = 0;
        nan  = 0;
        for (int i = 0; i < 4; i++) begin
            if (!nan) begin
                if (w[i][10:9] == 2'b11) begin
                    nan  = 1;
                    best = i;
                end else if (i > 0 && fkey(w[i]) > fkey(w[best])) begin
                    best = i;
                end
            end
        end
        return {nan, 8'(best), nan ? 11'h600 : w[best]};
    endfunction

    function automatic logic [19:0] model1(input logic [10:0] v);
        if (v[10:9] == 2'b11) return {1'b1, 8'd0, 11'h600};
        return {1'b0, 8'd0, v};
    endfunction

    // ---------------- WINDOW=4 scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_w4: unexpected result got=%h required=none",
                         {out_nan, out_idx, out_data});
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if ({out_nan, out_idx, out_data} !== e) begin
                    bad++;
                    $display("FAIL sb_w4: got nan=%b idx=%0d data=%h required nan=%b idx=%0d data=%h",
                             out_nan, out_idx, out_data, e[19], e[18:11], e[10:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [10:0] d);
        logic acc;
        bit   ok;
        ok       = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for data=%h", d);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_window(input logic [10:0] a, b, c, d, input int gap_max);
        win[0] = a; win[1] = b; win[2] = c; win[3] = d;
        exp_q.push_back(model4(a, b, c, d));
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
            send(win[i]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; rst1_n = 1'b0;
        in_valid = 1'b0; in_data = 11'd0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_data1 = 11'd0; out_ready1 = 1'b1;
        #12;
        total++;
        if ({out_valid, out_nan, out_idx, out_data} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {out_valid, out_nan, out_idx, out_data});
        end
        rst_n = 1'b1; rst1_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        win[0] = 11'h270; win[1] = 11'h280; win[2] = 11'h370;
        exp_q.push_back(model4(11'h270, 11'h280, 11'h370, 11'h270));
        for (int i = 0; i < 3; i++) begin
            send(win[i]);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL basic_early_valid: elem=%0d got %b required 0", i, out_valid);
            end
        end
        send(11'h270);
        // Result visible right after the edge that took the 4th element.
        total++;
        if ({out_valid, out_nan, out_idx, out_data} !== {1'b1, 1'b0, 8'd1, 11'h280}) begin
            bad++;
            $display("FAIL basic_latency: got v=%b nan=%b idx=%0d data=%h required v=1 nan=0 idx=1 data=280",
                     out_valid, out_nan, out_idx, out_data);
        end
        idle(1);
    endtask

    task automatic test_zero_tie;
        send_window(11'h500, 11'h000, 11'h100, 11'h370, 2);
        total++;
        if ({out_nan, out_idx, out_data} !== {1'b0, 8'd1, 11'h000}) begin
            bad++;
            $display("FAIL zero_tie: got nan=%b idx=%0d data=%h required nan=0 idx=1 data=000",
                     out_nan, out_idx, out_data);
        end
        idle(1);
    endtask

    task automatic test_nan;
        send_window(11'h270, 11'h600, 11'h400, 11'h280, 0);
        total++;
        if ({out_nan, out_idx, out_data} !== {1'b1, 8'd1, 11'h600}) begin
            bad++;
            $display("FAIL nan_sticky: got nan=%b idx=%0d data=%h required nan=1 idx=1 data=600",
                     out_nan, out_idx, out_data);
        end
        idle(1);
        // NaN first, later NaN and +inf must not move idx
        send_window(11'h6ff, 11'h400, 11'h600, 11'h280, 1);
        idle(1);
        // -inf first, +inf last wins
        send_window(11'h500, 11'h370, 11'h2f5, 11'h400, 1);
        idle(1);
    endtask

    task automatic test_backpressure;
        logic [19:0] held;
        out_ready = 1'b0;
        send_window(11'h2a3, 11'h3a3, 11'h2b1, 11'h2b1, 0);
        held = model4(11'h2a3, 11'h3a3, 11'h2b1, 11'h2b1);
        // Offer data during HOLD: it must not be taken.
        in_valid = 1'b1;
        in_data  = 11'h400;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_nan, out_idx, out_data} !== {1'b1, 1'b0, held}) begin
                bad++;
                $display("FAIL backpressure_hold: cyc=%0d got v=%b rdy=%b res=%h required v=1 rdy=0 res=%h",
                         i, out_valid, in_ready, {out_nan, out_idx, out_data}, held);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(1);
        send_window(11'h250, 11'h251, 11'h24f, 11'h300, 0);
        idle(1);
    endtask

    task automatic test_reset_mid;
        send(11'h400);
        send(11'h280);
        rst_n = 1'b0;
        #2;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_mid: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_window(11'h370, 11'h370, 11'h360, 11'h370, 0);
        total++;
        if ({out_nan, out_idx, out_data} !== {1'b0, 8'd2, 11'h360}) begin
            bad++;
            $display("FAIL reset_mid_result: got nan=%b idx=%0d data=%h required nan=0 idx=2 data=360",
                     out_nan, out_idx, out_data);
        end
        idle(1);
        // Reset while a result is pending: it is discarded.
        out_ready = 1'b0;
        send_window(11'h210, 11'h220, 11'h230, 11'h240, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got out_valid=%b required 0", out_valid);
        end
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(4);
    endtask

    task automatic test_random;
        logic [10:0] r [0:3];
        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < 4; i++) begin
                r[i] = 11'($urandom_range(0, 2047));
                if ($urandom_range(0, 5) != 0) r[i][10:9] = 2'b01;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            send_window(r[0], r[1], r[2], r[3], 3);
            idle($urandom_range(0, 3));
            out_ready = 1'b1;
            idle(1);
        end
    endtask

    task automatic test_window1;
        int nres;
        int cycles;
        logic [19:0] e;
        nres   = 0;
        cycles = 300;
        for (int c = 0; c < cycles + 4; c++) begin
            @(posedge clk);
            #1;
            if (c < cycles) begin
                in_valid1  = ($urandom_range(0, 3) != 0);
                in_data1   = 11'($urandom_range(0, 2047));
                out_ready1 = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid1  = 1'b0;
                out_ready1 = 1'b1;
            end
            @(negedge clk);
            total++;
            if (in_ready1 && out_valid1) begin
                bad++;
                $display("FAIL w1_bubble: in_ready=1 while out_valid=1 at cycle %0d", c);
            end
            if (in_valid1 && in_ready1) exp1_q.push_back(model1(in_data1));
            if (out_valid1 && out_ready1) begin
                nres++;
                total++;
                if (exp1_q.size() == 0) begin
                    bad++;
                    $display("FAIL w1_echo: unexpected result got=%h", {out_nan1, out_idx1, out_data1});
                end else begin
                    e = exp1_q.pop_front();
                    if ({out_nan1, out_idx1, out_data1} !== e) begin
                        bad++;
                        $display("FAIL w1_echo: got %h required %h", {out_nan1, out_idx1, out_data1}, e);
                    end
                end
            end
        end
        total++;
        if (nres == 0 || nres > cycles / 2 + 2) begin
            bad++;
            $display("FAIL w1_throughput: got %0d results required 1..%0d", nres, cycles / 2 + 2);
        end
    endtask

    task automatic test_drain;
        idle(4);
        total++;
        if (exp_q.size() != 0 || exp1_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending w4=%0d w1=%0d required 0 0", exp_q.size(), exp1_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_tie();
        test_nan();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_window1();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fmax_window.md
FMAX_WINDOW -- requirements
Module: fmax_window

Interface
REQ-001 The block SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 The block SHALL have parameter WINDOW, default 4, elements per reduction window; legal range 1..256.
REQ-003 The block SHALL have port clk, input, 1 bit: the only clock; all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port in_data, input, 11 bits: FloPoCo float wE=4 wF=4, laid out as {exc[10:9], sign[8], exp[7:4], frac[3:0]}.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-008 The block SHALL have port out_data, output, 11 bits: window maximum, same format.
REQ-009 The block SHALL have port out_idx, output, 8 bits: position within the window (0-based) of the reported element.
REQ-010 The block SHALL have port out_nan, output, 1 bit: window contained at least one NaN (exc=11).
REQ-011 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.

Function
REQ-013 The block SHALL instantiate fcmplt with X = running max, Y = in_data; replacement condition is XltY=1 and unordered=0.
REQ-014 The block SHALL accept an input when in_valid and in_ready are both high in the same cycle; no other event counts.
REQ-015 The FSM SHALL have three states: ACC0 (expecting element 0), ACC (elements 1..WINDOW-1), HOLD (result pending).
REQ-016 In ACC0, an accepted element SHALL load max=in_data, idx=0, nan=(exc==11), cnt=1; next state is ACC, or HOLD if WINDOW=1.
REQ-017 In ACC, an accepted element SHALL replace max/idx with in_data/cnt when REQ-013 holds and nan is 0; otherwise max and idx are unchanged.
REQ-018 Ties (comparator reports neither less nor unordered, including +0 vs -0) SHALL keep the earlier element and its index.
REQ-019 The first NaN accepted SHALL set nan sticky, force max to 11'h600 and idx to its position; later elements, NaN or not, SHALL NOT change max or idx.
REQ-020 cnt SHALL increment per accepted element; when the element at position WINDOW-1 is accepted, the next state is HOLD and cnt clears to 0.
REQ-021 in_ready SHALL be 1 in ACC0 and ACC and 0 in HOLD (registered-state decode, no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 exactly in HOLD; out_data/out_idx/out_nan SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-023 Latency: out_valid SHALL rise on the clock edge that accepts the last window element (visible the following cycle).
REQ-024 In HOLD, out_ready=1 SHALL transition to ACC0 on that edge; the next element can be accepted in the following cycle (1 bubble per window).
REQ-025 in_valid gaps of any length SHALL stall accumulation without loss or state change.
REQ-026 Infinities SHALL order as -inf < all normals/zero < +inf, per fcmplt semantics; no special casing in this block.

Reset
REQ-027 rst_n low SHALL asynchronously force state=ACC0, cnt=0, max=0, idx=0, nan=0, out_valid=0; in_ready SHALL read 1 once rst_n is high.
REQ-028 Reset asserted mid-window or in HOLD SHALL discard the partial or pending result; no out_valid is produced for it.
REQ-029 Reset deassertion SHALL be synchronised externally; the block requires no cycles after release before accepting input.

Verification
REQ-030 WINDOW=4, inputs 0x270 (1.0), 0x280 (2.0), 0x370 (-1.0), 0x270 -> out_data=0x280, out_idx=1, out_nan=0, out_valid the cycle after the 4th accept.
REQ-031 WINDOW=4, inputs 0x500 (-inf), 0x000 (+0), 0x100 (-0), 0x370 -> out_data=0x000, out_idx=1 (tie keeps earliest).
REQ-032 WINDOW=4, inputs 0x270, 0x600 (NaN), 0x400 (+inf), 0x280 -> out_data=0x600, out_idx=1, out_nan=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs constant, in_ready=0; then out_ready=1 -> next window accumulates correctly.
REQ-034 Reset pulse after 2 of 4 elements, then 4 new elements 0x370,0x370,0x360,0x370 -> single result out_data=0x360, out_idx=2.
REQ-035 WINDOW=1 with random in_valid/out_ready -> every accepted element is echoed with out_idx=0, throughput one result per 2 cycles maximum.
